// File: rtl/randomizer_check.sv
`default_nettype none
// ============================================================================
// Module   : randomizer_check
// Brief    : Locks onto a received randomizer word stream, then flags and
//            counts mismatches against its own free-running copy. Define
//            RANDOMIZER_CHECK_BIT_ERRORS_EN to count bit errors, not words.
// Revision : 1.0 - initial release
// ============================================================================
module randomizer_check #(
    parameter int OUTPUT_WIDTH = 32,
    parameter int LOCK_COUNT   = 4,
    parameter int LOSS_COUNT   = 3,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OUTPUT_WIDTH-1:0] chk_in,
    input  logic                    chk_valid,
    input  logic                    chk_clear,
    output logic                    chk_locked,
    output logic                    chk_error,
    output logic [ERR_WIDTH-1:0]    chk_err_count
);

    // Tap positions per supported width, as a bit mask over the current word.
    localparam logic [31:0] c_TAP_MASK =
        (OUTPUT_WIDTH == 8)  ? 32'h0000_0070 :
        (OUTPUT_WIDTH == 16) ? 32'h0000_A010 :
        (OUTPUT_WIDTH == 24) ? 32'h00C2_0000 :
                               32'h0040_0006;
    localparam logic [OUTPUT_WIDTH-1:0] c_TAPS = c_TAP_MASK[OUTPUT_WIDTH-1:0];

    localparam int c_INC_W = 6;
    localparam int c_SUM_W = ((ERR_WIDTH > c_INC_W) ? ERR_WIDTH : c_INC_W) + 1;
    localparam logic [c_SUM_W-1:0] c_ERR_MAX =
        {{(c_SUM_W-ERR_WIDTH){1'b0}}, {ERR_WIDTH{1'b1}}};
    localparam logic [7:0] c_LOCK = 8'(LOCK_COUNT);
    localparam logic [7:0] c_LOSS = 8'(LOSS_COUNT);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Sequence step: shift right with c[0] fed to the top, XNOR on taps;
    // the all-ones lock-up word is mapped to zero.
    function automatic logic [OUTPUT_WIDTH-1:0] step(input logic [OUTPUT_WIDTH-1:0] c);
        logic [OUTPUT_WIDTH-1:0] n;
        n = '0;
        n[OUTPUT_WIDTH-1] = c[0];
        for (int i = OUTPUT_WIDTH - 1; i >= 1; i--) begin
            n[i-1] = c_TAPS[i] ? ~(c[i] ^ c[0]) : c[i];
        end
        if (&n) begin
            n = '0;
        end
        return n;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OUTPUT_WIDTH-1:0] r_exp;
    logic [OUTPUT_WIDTH-1:0] w_exp_nxt;
    logic [7:0]              r_match;
    logic [7:0]              w_match_nxt;
    logic [7:0]              r_miss;
    logic [7:0]              w_miss_nxt;
    logic                    r_first;
    logic                    w_first_nxt;
    logic                    r_error;
    logic                    w_error_nxt;
    logic [ERR_WIDTH-1:0]    r_err_count;
    logic [ERR_WIDTH-1:0]    w_err_count_nxt;

    logic [OUTPUT_WIDTH-1:0] w_step_in;
    logic [OUTPUT_WIDTH-1:0] w_step_exp;
    logic                    w_mismatch;
    logic [7:0]              w_match_inc;
    logic [7:0]              w_miss_inc;
    logic [c_INC_W-1:0]      w_inc;
    logic [c_SUM_W-1:0]      w_sum;
    logic [ERR_WIDTH-1:0]    w_sat;

    assign w_step_in   = step(chk_in);
    assign w_step_exp  = step(r_exp);
    // The expected word can never be all ones, so an all-ones input always misses.
    assign w_mismatch  = (chk_in != r_exp) || (&chk_in);
    assign w_match_inc = r_match + 8'd1;
    assign w_miss_inc  = r_miss + 8'd1;

`ifdef RANDOMIZER_CHECK_BIT_ERRORS_EN
    function automatic logic [c_INC_W-1:0] popcount(input logic [OUTPUT_WIDTH-1:0] v);
        logic [c_INC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            cnt = cnt + {{(c_INC_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [OUTPUT_WIDTH-1:0] w_diff;
    assign w_diff = chk_in ^ r_exp;
    assign w_inc  = popcount(w_diff);
`else
    assign w_inc  = {{(c_INC_W-1){1'b0}}, 1'b1};
`endif

    assign w_sum = c_SUM_W'(r_err_count) + c_SUM_W'(w_inc);
    assign w_sat = (w_sum > c_ERR_MAX) ? c_ERR_MAX[ERR_WIDTH-1:0] : w_sum[ERR_WIDTH-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_exp_nxt       = r_exp;
        w_match_nxt     = r_match;
        w_miss_nxt      = r_miss;
        w_first_nxt     = r_first;
        w_error_nxt     = 1'b0;
        w_err_count_nxt = r_err_count;

        if (chk_valid) begin
            case (r_state)
                ST_UNLOCKED: begin
                    // Re-seed from the received word until enough words agree.
                    w_exp_nxt = w_step_in;
                    if (r_first) begin
                        w_first_nxt = 1'b0;
                        w_match_nxt = 8'd0;
                    end else if (!w_mismatch) begin
                        if (w_match_inc == c_LOCK) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = 8'd0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_match_nxt = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    w_exp_nxt = w_step_exp;
                    if (w_mismatch) begin
                        w_error_nxt     = 1'b1;
                        w_err_count_nxt = w_sat;
                        if (w_miss_inc == c_LOSS) begin
                            w_state_nxt = ST_UNLOCKED;
                            w_miss_nxt  = 8'd0;
                            w_first_nxt = 1'b1;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end else begin
                        w_miss_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                end
            endcase
        end

        if (chk_clear) begin
            w_error_nxt     = 1'b0;
            w_err_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_UNLOCKED;
            r_exp       <= '0;
            r_match     <= 8'd0;
            r_miss      <= 8'd0;
            r_first     <= 1'b1;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_match     <= w_match_nxt;
            r_miss      <= w_miss_nxt;
            r_first     <= w_first_nxt;
            r_error     <= w_error_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign chk_locked    = (r_state == ST_LOCKED);
    assign chk_error     = r_error;
    assign chk_err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/randomizer_check.md
RANDOMIZER_CHECK -- requirements
Module: randomizer_check

Interface
- REQ-001 SHALL have parameter OUTPUT_WIDTH, default 32: word width W of the checked sequence; legal values 8, 16, 24, 32.
- REQ-002 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words needed to lock (1..255).
- REQ-003 SHALL have parameter LOSS_COUNT, default 3: consecutive mismatching words that drop lock (1..255).
- REQ-004 SHALL have parameter ERR_WIDTH, default 16: width of the error counter.
- REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
- REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-007 SHALL have port chk_in, input, W: received randomizer word.
- REQ-008 SHALL have port chk_valid, input, 1: chk_in is sampled this cycle.
- REQ-009 SHALL have port chk_clear, input, 1: synchronous clear of error counter and error flag.
- REQ-010 SHALL have port chk_locked, output, 1: checker is tracking the sequence.
- REQ-011 SHALL have port chk_error, output, 1: one-cycle pulse, mismatch detected while locked.
- REQ-012 SHALL have port chk_err_count, output, ERR_WIDTH: saturating error count.

Function
- REQ-013 SHALL compute step f(c) with c[0] as feedback bit: n[W-1]=c[0]; for i=W-1..1, n[i-1] = c[i] XNOR c[0] if i is a tap, else c[i]; if n is all ones, n is forced to 0.
- REQ-014 SHALL use taps W=8: {6,5,4}; W=16: {15,13,4}; W=24: {23,22,17}; W=32: {22,2,1}.
- REQ-015 SHALL implement states UNLOCKED and LOCKED; W-bit register exp holds the next expected word; a first-word flag is set after reset.
- REQ-016 In UNLOCKED, per valid word: if the first-word flag is set, load exp=f(chk_in), clear the flag, leave match count at 0; else if chk_in==exp, increment match count, otherwise clear it; in both cases load exp=f(chk_in).
- REQ-017 SHALL enter LOCKED in the cycle after the match count reaches LOCK_COUNT, then clear match count.
- REQ-018 In LOCKED, per valid word: exp=f(exp), free-running and independent of chk_in; on mismatch pulse chk_error, increment the error counter and the miss count; on match clear the miss count.
- REQ-019 SHALL return to UNLOCKED when the miss count reaches LOSS_COUNT, then clear the miss count and set the first-word flag.
- REQ-020 Words with chk_valid low SHALL be ignored: no state, exp or counter change.
- REQ-021 chk_locked, chk_error and chk_err_count SHALL be registered; each updates one cycle after the sampling edge.
- REQ-022 The error counter SHALL saturate at 2^ERR_WIDTH-1 and never wrap.
- REQ-023 chk_clear SHALL zero the counter and suppress chk_error; if it coincides with an error, clear wins; lock state is unaffected.
- REQ-024 An all-ones chk_in SHALL count as a mismatch when compared, and f(chk_in) SHALL still be loaded.

Reset
- REQ-025 On rst_n low: state UNLOCKED, chk_locked=0, chk_error=0, chk_err_count=0, exp=0, match and miss counts 0, first-word flag set.
- REQ-026 Reset asserted mid-operation SHALL apply immediately; outputs SHALL stay at reset values until rst_n is deasserted and the next edge occurs.

Configuration
- REQ-027 Macro RANDOMIZER_CHECK_BIT_ERRORS_EN defined: each mismatch adds the popcount of (chk_in XOR exp) to the counter, still saturating.
- REQ-028 Macro RANDOMIZER_CHECK_BIT_ERRORS_EN undefined: each mismatching word adds 1; there is no popcount logic.

Verification
- REQ-029 W=8, LOCK_COUNT=4: feed 0x00, 0x38, 0x24, ... (f-chain) with valid every cycle -> chk_locked=1 one cycle after the 5th word, err_count=0.
- REQ-030 Locked W=8: replace one word with itself XOR 0x01 -> single chk_error pulse, err_count=1 (bit mode 1), lock kept, next correct word matches.
- REQ-031 Locked, LOSS_COUNT=3: 3 consecutive corrupted words -> err_count=3, chk_locked=0 after the 3rd; resuming the chain relocks after 5 words.
- REQ-032 Bit mode: one word XOR 0xFF while locked -> err_count +8; word mode -> +1.
- REQ-033 ERR_WIDTH=4: 20 isolated errors -> err_count holds 15; chk_clear in the same cycle as an error -> count 0, no pulse.
- REQ-034 Gaps in chk_valid between chain words -> same lock timing in valid words; rst_n pulse while locked -> all outputs 0 immediately.
